mesh_wb_collector: RTL
======================

Name: mesh_wb_collector

Overview:
- Downstream stage of the mesh sorter (mesh_db).
- After the sort phase finishes, it captures the N per-node result packets {valid, addr, data}, scans them one slot per cycle, and commits each valid packet into an N-entry write-back memory.
- Signals completion with a one-cycle done pulse.
- Provides the committed memory image that the write-path benches check.

Parameters:
- N, 16, number of mesh nodes / result slots; N <= 2**ADDR_WIDTH.
- SQRT_N, 4, mesh side length (informational, kept for instantiation symmetry with mesh_db).
- ADDR_WIDTH, 4, packet address field width.
- DATA_WIDTH, 4, packet data field width.
- WIDTH, ADDR_WIDTH+DATA_WIDTH, packet payload width. The packet is WIDTH+1 bits: bit WIDTH = valid, [WIDTH-1:DATA_WIDTH] = addr, [DATA_WIDTH-1:0] = data.

Ports:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- sort_done, in, 1, single-cycle pulse from the sorter: results are stable this cycle.
- result_flat, in, N*(WIDTH+1), slot k at [k*(WIDTH+1) +: WIDTH+1], already address-sorted.
- mem_flat, out, N*DATA_WIDTH, committed memory; entry a at [a*DATA_WIDTH +: DATA_WIDTH].
- busy, out, 1, high in CAPTURE/SCAN/DONE.
- done, out, 1, one-cycle pulse when the commit is complete.
- write_count, out, ADDR_WIDTH+1, number of packets committed in the last pass.
- overrun, out, 1, sticky: sort_done arrived while busy.
- conflict, out, 1, sticky duplicate-address flag (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; all mem entries = 0; snapshot = 0; scan index = 0.
  - busy = 0, done = 0, write_count = 0, overrun = 0, conflict = 0.
- States:
  - IDLE: on sort_done=1, snapshot <= result_flat, index <= 0, write_count <= 0, next state SCAN (CAPTURE is folded into this edge).
  - SCAN: each cycle processes slot[index].
    - If valid=1 and addr < N: mem[addr] <= data and write_count += 1.
    - If valid=0 or addr >= N: nothing is written or counted.
    - When index == N-1, next state is DONE; otherwise index += 1.
  - DONE: done = 1 for exactly this cycle; next state IDLE.
- Latency: with sort_done sampled at edge E0, slot k is written at edge E0+1+k. done is high in the cycle after edge E0+N, which is a total of N+1 cycles. When done is high, mem_flat and write_count are final.
- Duplicate addresses: slots are processed in ascending slot order, so the highest-indexed valid packet wins. write_count counts every committed write, duplicates included.
- sort_done while busy (SCAN or DONE): ignored, snapshot unchanged, overrun <= 1. overrun is cleared only by rst.
- Entries not written in a pass keep their previous value. There is no clear between passes.
- rst mid-SCAN: immediate return to reset values. Partially written entries are lost and zeroed.
- write_count saturates naturally. Maximum is N, and its width holds N.

Optional Feature:
- Macro: MESH_WB_CONFLICT_EN.
- Defined:
  - During SCAN, the previous valid slot's addr is compared with the current valid slot's addr. This is valid because the input is sorted, so duplicates are adjacent.
  - On equality, conflict <= 1 (sticky until rst).
  - The compare register resets at each new pass.
- Undefined: conflict is tied to 0 and no compare logic is built.

Decomposition:
- Package mesh_pkg:
  - Field offsets VALID_BIT, ADDR_LSB, DATA_LSB.
  - Function pkt_width(ADDR_WIDTH, DATA_WIDTH).
  - State encoding constants WB_IDLE/WB_SCAN/WB_DONE.
  - Shared by mesh_db and this block.
- Sub-module mesh_wb_dup_detect: the adjacent-address comparator plus sticky flag. It is instantiated only under MESH_WB_CONFLICT_EN.
- Everything else stays in one module.

Test Plan:
- Reset, then hold 30 cycles with no sort_done → mem_flat=0, busy=0, done never high, write_count=0.
- Slots k=0..15 = {1, k, 4'hF}; pulse sort_done at cycle 10 → done high exactly at cycle 27 (N+1 later), all mem entries 4'b1111, write_count=16, busy low at cycle 28.
- Even slots valid {1, k, k[3:0]}, odd slots valid=0 → only even mem entries = k; odd entries keep the prior pass's value; write_count=8.
- Slots 3 and 4 both addr 5, data 4'h2 then 4'h9 → mem[5]=4'h9, write_count=16. conflict=1 with MESH_WB_CONFLICT_EN defined, 0 without.
- Second sort_done 5 cycles into SCAN with different data → overrun=1, mem reflects only the first snapshot, done pulses once.
- Assert rst at scan index 7 → all outputs at reset values within the same cycle. A following full pass completes normally with overrun=0.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh sorter (mesh_db) and its write-back collector:
// packet field layout, packet width helper and collector state encoding.
package mesh_pkg;

   localparam int MESH_ADDR_WIDTH = 4;
   localparam int MESH_DATA_WIDTH = 4;

   // Packet layout, LSB first: data, then addr, then the valid flag on top.
   localparam int DATA_LSB  = 0;
   localparam int ADDR_LSB  = DATA_LSB + MESH_DATA_WIDTH;
   localparam int VALID_BIT = ADDR_LSB + MESH_ADDR_WIDTH;

   function automatic int pkt_width(input int addr_width, input int data_width);
      return addr_width + data_width + 1;
   endfunction

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_SCAN = 2'd1,
      WB_DONE = 2'd2
   } wb_state_t;

endpackage

// File: rtl/mesh_wb_dup_detect.sv
// Adjacent-address duplicate detector for the write-back scan; relies on the
// slots arriving address-sorted so that any duplicates sit next to each other.
module mesh_wb_dup_detect #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  en,
   input  logic                  slot_valid,
   input  logic [ADDR_WIDTH-1:0] slot_addr,
   output logic                  conflict
);

   logic                  prev_valid_reg;
   logic [ADDR_WIDTH-1:0] prev_addr_reg;
   logic                  conflict_reg;

   // Invalid slots are skipped, so the compare is always against the last valid one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_valid_reg <= 1'b0;
         prev_addr_reg  <= '0;
         conflict_reg   <= 1'b0;
      end else if (clear) begin
         prev_valid_reg <= 1'b0;
      end else if (en && slot_valid) begin
         if (prev_valid_reg && (prev_addr_reg == slot_addr)) begin
            conflict_reg <= 1'b1;
         end
         prev_valid_reg <= 1'b1;
         prev_addr_reg  <= slot_addr;
      end
   end

   assign conflict = conflict_reg;

endmodule

// File: rtl/mesh_wb_collector.sv
// Write-back collector: snapshots the sorted result packets, commits one slot per
// cycle into an N-entry memory, then pulses done. MESH_WB_CONFLICT_EN adds duplicate detection.
module mesh_wb_collector
   import mesh_pkg::*;
#(
   parameter int N          = 16,
   parameter int SQRT_N     = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 4,
   parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sort_done,
   input  logic [N*(WIDTH+1)-1:0]    result_flat,
   output logic [N*DATA_WIDTH-1:0]   mem_flat,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_WIDTH:0]       write_count,
   output logic                      overrun,
   output logic                      conflict
);

   localparam int                  PKT_W      = pkt_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int                  IDX_W      = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N - 1);
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(N);

   wb_state_t             state_reg;
   logic [IDX_W-1:0]      index_reg;
   logic [N*PKT_W-1:0]    snapshot_reg;
   logic [ADDR_WIDTH:0]   write_count_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  overrun_reg;

   logic [PKT_W-1:0]      slot;
   logic                  slot_valid;
   logic [ADDR_WIDTH-1:0] slot_addr;
   logic [DATA_WIDTH-1:0] slot_data;
   logic                  scanning;
   logic                  commit;

   assign slot       = snapshot_reg[index_reg*PKT_W +: PKT_W];
   assign slot_valid = slot[WIDTH];
   assign slot_addr  = slot[DATA_LSB + DATA_WIDTH +: ADDR_WIDTH];
   assign slot_data  = slot[DATA_LSB +: DATA_WIDTH];
   assign scanning   = (state_reg == WB_SCAN);
   // Addresses beyond the memory depth are dropped rather than aliased.
   assign commit     = scanning && slot_valid && ({1'b0, slot_addr} < ADDR_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= WB_IDLE;
         index_reg       <= '0;
         snapshot_reg    <= '0;
         write_count_reg <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         case (state_reg)
            WB_IDLE: begin
               done_reg <= 1'b0;
               if (sort_done) begin
                  snapshot_reg    <= result_flat;
                  index_reg       <= '0;
                  write_count_reg <= '0;
                  busy_reg        <= 1'b1;
                  state_reg       <= WB_SCAN;
               end
            end
            WB_SCAN: begin
               if (commit) begin
                  write_count_reg <= write_count_reg + 1'b1;
               end
               if (sort_done) begin
                  overrun_reg <= 1'b1;
               end
               if (index_reg == LAST_IDX) begin
                  done_reg  <= 1'b1;
                  state_reg <= WB_DONE;
               end else begin
                  index_reg <= index_reg + 1'b1;
               end
            end
            WB_DONE: begin
               if (sort_done) begin
                  overrun_reg <= 1'b1;
               end
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= WB_IDLE;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= WB_IDLE;
            end
         endcase
      end
   end

   // One register per entry; later slots overwrite earlier ones, so the highest slot wins.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_mem
         logic entry_hit;
         logic [DATA_WIDTH-1:0] entry_reg;

         assign entry_hit = commit && (slot_addr == ADDR_WIDTH'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (entry_hit) begin
               entry_reg <= slot_data;
            end
         end

         assign mem_flat[gi*DATA_WIDTH +: DATA_WIDTH] = entry_reg;
      end
   endgenerate

`ifdef MESH_WB_CONFLICT_EN
   mesh_wb_dup_detect #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dup_detect (
      .clk        (clk),
      .rst        (rst),
      .clear      ((state_reg == WB_IDLE) && sort_done),
      .en         (scanning),
      .slot_valid (slot_valid),
      .slot_addr  (slot_addr),
      .conflict   (conflict)
   );
`else
   assign conflict = 1'b0;
`endif

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign write_count = write_count_reg;
   assign overrun     = overrun_reg;

endmodule
